// File: rtl/divider_pkg.sv
// Shared types and constants for the 16-by-8 sequential restoring divider.
package divider_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int CNT_W      = 5;

  // Counter value seen on the final of the 16 iterations.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  // Quotient reported when the divisor is zero.
  localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_16by8_if.sv
// Operand/result handshake bundle between a source/sink and the divider.
interface seq_divider_16by8_if;
  import divider_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  // Operand source and result sink side.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_16by8_div_step.sv
// One restoring-division iteration: shift in one dividend bit, trial-subtract.
module div_step
  import divider_pkg::*;
(
  input  logic [DIVISOR_W:0]   pr,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_next,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] pr_shift;

  // pr[8] is never set while the remainder stays below the divisor; it still
  // forces a subtract so the step is correct for any 9-bit input.
  always_comb begin
    pr_shift = {pr[DIVISOR_W-1:0], bit_in};
    q_bit    = pr[DIVISOR_W] | (pr_shift >= {1'b0, divisor});
    pr_next  = q_bit ? (pr_shift - {1'b0, divisor}) : pr_shift;
  end

endmodule

// File: rtl/seq_divider_16by8.sv
// 16-by-8 unsigned restoring divider, one quotient bit per clock, valid/ready
// on both sides. Divide-by-zero completes immediately with a flagged result.
module seq_divider_16by8
  import divider_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  seq_divider_16by8_if.slave  bus
);

  state_t state, state_nxt;

  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    pr;
  logic [CNT_W-1:0]      cnt;

  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  dbz_q;
  logic                  out_valid_q;

  logic [DIVISOR_W:0]    pr_next;
  logic                  q_bit;
  logic                  accept;
  logic                  last_iter;
  logic                  release_result;

  assign accept         = bus.in_valid && (state == IDLE);
  assign last_iter      = (state == BUSY) && (cnt == LAST_ITER);
  assign release_result = (state == DONE) && bus.out_ready;

  div_step u_step (
    .pr      (pr),
    .bit_in  (dvd[DIVIDEND_W-1]),
    .divisor (dvs),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (bus.divisor == '0) ? DONE : BUSY;
      BUSY: if (last_iter) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration shift, result load and release.
  // Quotient bits shift into the vacated LSBs of the dividend register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd         <= '0;
      dvs         <= '0;
      pr          <= '0;
      cnt         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      dvd <= bus.dividend;
      dvs <= bus.divisor;
      pr  <= '0;
      cnt <= '0;
      if (bus.divisor == '0) begin
        quotient_q  <= DBZ_QUOTIENT;
        remainder_q <= bus.dividend[DIVISOR_W-1:0];
        dbz_q       <= 1'b1;
        out_valid_q <= 1'b1;
      end
    end else if (state == BUSY) begin
      dvd <= {dvd[DIVIDEND_W-2:0], q_bit};
      pr  <= pr_next;
      cnt <= cnt + 1'b1;
      if (last_iter) begin
        quotient_q  <= {dvd[DIVIDEND_W-2:0], q_bit};
        remainder_q <= pr_next[DIVISOR_W-1:0];
        dbz_q       <= 1'b0;
        out_valid_q <= 1'b1;
      end
    end else if (release_result) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Self-checking bench for seq_divider_16by8: directed vector table, handshake
// corner sequences and a randomized run against an arithmetic reference.
module tb_seq_divider_16by8;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider_16by8_if bus ();

  seq_divider_16by8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands, wait for acceptance, then count clock edges after the
  // accept edge until out_valid appears. lat = -1 on timeout.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_op", {31'b0, bus.in_ready}, 32'd1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  // Accept the pending result and confirm out_valid drops.
  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("out_valid_cleared", {31'b0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [15:0] q_hold;
    logic [7:0]  r_hold;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] mq;
    logic [7:0]  mr;
    logic        mdbz;

    vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 16};
    vecs[1] = '{16'hFFFF,  8'h01,  16'hFFFF,  8'h00,  1'b0, 16};
    vecs[2] = '{16'h00FF,  8'hFF,  16'd1,     8'h00,  1'b0, 16};
    vecs[3] = '{16'h1234,  8'h00,  16'hFFFF,  8'h34,  1'b1, 0};
    vecs[4] = '{16'd5000,  8'd13,  16'd384,   8'd8,   1'b0, 16};
    vecs[5] = '{16'hFFFF,  8'hFF,  16'd257,   8'd0,   1'b0, 16};
    vecs[6] = '{16'd0,     8'd5,   16'd0,     8'd0,   1'b0, 16};
    vecs[7] = '{16'd254,   8'd255, 16'd0,     8'd254, 1'b0, 16};

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;

    // Operands presented during reset must be ignored.
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 16'h4321;
    bus.divisor  = 8'd3;
    @(negedge clk);
    check("rst_out_valid",   {31'b0, bus.out_valid},   32'd0);
    check("rst_quotient",    {16'b0, bus.quotient},    32'd0);
    check("rst_remainder",   {24'b0, bus.remainder},   32'd0);
    check("rst_div_by_zero", {31'b0, bus.div_by_zero}, 32'd0);
    check("rst_in_ready",    {31'b0, bus.in_ready},    32'd1);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_rst", {31'b0, bus.out_valid}, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].dividend, vecs[i].divisor, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_quotient", i), {16'b0, bus.quotient}, {16'b0, vecs[i].exp_q});
      check($sformatf("vec%0d_remainder", i), {24'b0, bus.remainder}, {24'b0, vecs[i].exp_r});
      check($sformatf("vec%0d_dbz", i), {31'b0, bus.div_by_zero}, {31'b0, vecs[i].exp_dbz});
      check($sformatf("vec%0d_in_ready_done", i), {31'b0, bus.in_ready}, 32'd0);
      consume();
    end

    // Backpressure: result must hold for 5 cycles with out_ready low.
    run_op(16'd1000, 8'd7, lat);
    check("bp_latency", lat, 16);
    q_hold = 16'd142;
    r_hold = 8'd6;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp_in_ready",  {31'b0, bus.in_ready},  32'd0);
      check("bp_quotient",  {16'b0, bus.quotient},  {16'b0, q_hold});
      check("bp_remainder", {24'b0, bus.remainder}, {24'b0, r_hold});
    end
    consume();

    // in_valid pulsed during BUSY must be ignored.
    @(negedge clk);
    bus.dividend = 16'd300;
    bus.divisor  = 8'd10;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.dividend = 16'd9999;
    bus.divisor  = 8'd2;
    bus.in_valid = 1'b1;
    check("busy_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 5;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("busy_pulse_latency", lat, 16);
    check("busy_pulse_quotient",  {16'b0, bus.quotient},  32'd30);
    check("busy_pulse_remainder", {24'b0, bus.remainder}, 32'd0);
    consume();
    repeat (20) @(posedge clk);
    #1;
    check("no_second_result", {31'b0, bus.out_valid}, 32'd0);
    check("idle_in_ready",    {31'b0, bus.in_ready},  32'd1);

    // Reset at iteration 8 discards the operation.
    @(negedge clk);
    bus.dividend = 16'hABCD;
    bus.divisor  = 8'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid",   {31'b0, bus.out_valid},   32'd0);
    check("midrst_quotient",    {16'b0, bus.quotient},    32'd0);
    check("midrst_remainder",   {24'b0, bus.remainder},   32'd0);
    check("midrst_div_by_zero", {31'b0, bus.div_by_zero}, 32'd0);
    check("midrst_in_ready",    {31'b0, bus.in_ready},    32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd5000, 8'd13, lat);
    check("postrst_latency",   lat, 16);
    check("postrst_quotient",  {16'b0, bus.quotient},  32'd384);
    check("postrst_remainder", {24'b0, bus.remainder}, 32'd8);
    consume();

    // Randomized run against an arithmetic reference.
    for (int n = 0; n < 2000; n++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 15))
        0:       b = 8'd0;
        1:       b = 8'd1;
        2:       b = 8'd255;
        default: b = 8'($urandom);
      endcase
      if (b == 8'd0) begin
        mq = 16'hFFFF;
        mr = a[7:0];
        mdbz = 1'b1;
      end else begin
        mq = a / b;
        mr = 8'(a % b);
        mdbz = 1'b0;
      end
      run_op(a, b, lat);
      check("rnd_latency",   lat, mdbz ? 0 : 16);
      check("rnd_quotient",  {16'b0, bus.quotient},    {16'b0, mq});
      check("rnd_remainder", {24'b0, bus.remainder},   {24'b0, mr});
      check("rnd_dbz",       {31'b0, bus.div_by_zero}, {31'b0, mdbz});
      if (!mdbz) begin
        check("rnd_invariant", 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
        check("rnd_rem_lt_div", {31'b0, (bus.remainder < b)}, 32'd1);
        if (bus.quotient[15:8] == 8'd0)
          check("rnd_product", 32'(16'(bus.quotient[7:0] * b) + 16'(bus.remainder)), 32'(a));
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      consume();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
